// File: rtl/pmem_boot_loader_if.sv
// Byte-source handshake and PMEM (ic1) single-cycle write channel used by pmem_boot_loader.
// master: the loader side; slave: the byte source / PMEM side.
interface pmem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        ic1_axi_mst_wr_valid;
  logic [31:0] ic1_axi_mst_wr_addr;
  logic [31:0] ic1_axi_mst_wr_data;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, ic1_axi_mst_wr_valid, ic1_axi_mst_wr_addr, ic1_axi_mst_wr_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, ic1_axi_mst_wr_valid, ic1_axi_mst_wr_addr, ic1_axi_mst_wr_data
  );
endinterface

// File: rtl/pmem_boot_loader.sv
// Framed byte-stream loader: A5 | N lo | N hi | 4*N bytes, packed LE into PMEM words.
// Define PMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte before DONE.
module pmem_boot_loader #(
  parameter int unsigned PMEM_WORDS = 512,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pmem_boot_loader_if.master bus,
  input  logic               reload,
  output logic               cpu_rst_n,
  output logic               load_done,
  output logic               load_err
);
  localparam int unsigned IDX_W     = (PMEM_WORDS > 1) ? $clog2(PMEM_WORDS) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, DONE, ERROR
`ifdef PMEM_LOADER_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  state_t           state, state_nxt;
  logic             rx_ready_nxt, done_nxt, err_nxt;
  logic [CNT_W-1:0] len_q;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_q;
`ifdef PMEM_LOADER_CKSUM_EN
  logic [7:0]       cksum_q;
`endif

  logic             accept_c;
  logic [CNT_W-1:0] len_full_c;
  logic             word_end_c;
  logic             last_word_c;

  assign accept_c    = bus.rx_valid & bus.rx_ready;
  assign len_full_c  = CNT_W'({bus.rx_data, len_q[7:0]});
  assign word_end_c  = (byte_cnt == 2'd3);
  assign last_word_c = (CNT_W'(word_idx) == (len_q - CNT_W'(1)));

  // Next state and next values of the registered status outputs
  always_comb begin
    state_nxt    = state;
    rx_ready_nxt = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: if (accept_c && (bus.rx_data == SYNC_BYTE)) state_nxt = LEN0;
      LEN0: if (accept_c) state_nxt = LEN1;
      LEN1: if (accept_c) begin
        if ((len_full_c == '0) || (len_full_c > CNT_W'(PMEM_WORDS))) state_nxt = ERROR;
        else                                                          state_nxt = DATA;
      end
      DATA: if (accept_c && word_end_c && last_word_c) begin
`ifdef PMEM_LOADER_CKSUM_EN
        state_nxt = CKSUM;
`else
        state_nxt = DONE;
`endif
      end
`ifdef PMEM_LOADER_CKSUM_EN
      CKSUM: if (accept_c) state_nxt = (bus.rx_data == cksum_q) ? DONE : ERROR;
`endif
      DONE, ERROR: if (reload) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    rx_ready_nxt = (state_nxt != DONE) && (state_nxt != ERROR);
    done_nxt     = (state_nxt == DONE);
    err_nxt      = (state_nxt == ERROR);
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.rx_ready <= 1'b0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.rx_ready <= rx_ready_nxt;
      cpu_rst_n    <= done_nxt;
      load_done    <= done_nxt;
      load_err     <= err_nxt;
    end
  end

  // Length capture, word assembly and PMEM write issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q                    <= '0;
      word_idx                 <= '0;
      byte_cnt                 <= '0;
      asm_q                    <= '0;
      bus.ic1_axi_mst_wr_valid <= 1'b0;
      bus.ic1_axi_mst_wr_addr  <= '0;
      bus.ic1_axi_mst_wr_data  <= '0;
`ifdef PMEM_LOADER_CKSUM_EN
      cksum_q                  <= '0;
`endif
    end else begin
      bus.ic1_axi_mst_wr_valid <= 1'b0;
      case (state)
        IDLE: begin
          word_idx <= '0;
          byte_cnt <= '0;
`ifdef PMEM_LOADER_CKSUM_EN
          cksum_q  <= '0;
`endif
        end
        LEN0: if (accept_c) len_q[7:0] <= bus.rx_data;
        LEN1: if (accept_c) len_q <= len_full_c;
        DATA: if (accept_c) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= {bus.rx_data, asm_q[23:8]};
`ifdef PMEM_LOADER_CKSUM_EN
          cksum_q  <= cksum_q ^ bus.rx_data;
`endif
          // Fourth byte: completed word goes out on the next cycle
          if (word_end_c) begin
            bus.ic1_axi_mst_wr_valid <= 1'b1;
            bus.ic1_axi_mst_wr_addr  <= 32'(word_idx);
            bus.ic1_axi_mst_wr_data  <= {bus.rx_data, asm_q};
            if (!last_word_c) word_idx <= word_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_boot_loader.sv
// Self-checking bench for pmem_boot_loader: scoreboard of expected PMEM writes
// (address, data, issue cycle) plus status checks around each frame.
module tb_pmem_boot_loader;
  localparam int unsigned PMEM_WORDS = 512;
  localparam int unsigned LIMIT      = 100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic reload;
  logic cpu_rst_n, load_done, load_err;
  logic [31:0] cyc = '0;
  int n_cmp = 0;
  int n_err = 0;
  wr_exp_t exp_q[$];

  pmem_boot_loader_if bus ();

  pmem_boot_loader #(.PMEM_WORDS(PMEM_WORDS), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .reload   (reload),
    .cpu_rst_n(cpu_rst_n),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (rst_n && bus.ic1_axi_mst_wr_valid) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", bus.ic1_axi_mst_wr_addr, 32'hFFFF_FFFF);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.ic1_axi_mst_wr_addr, e.addr);
        check("wr_data", bus.ic1_axi_mst_wr_data, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < int'(LIMIT)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= int'(LIMIT)) check("rx_ready_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_image(input logic [7:0] lead[$], input logic [15:0] n,
                            input logic [31:0] words[$], input logic [7:0] ck_flip);
    logic [7:0] ck;
    logic [7:0] d;
    ck = ck_flip;
    foreach (lead[i]) send_byte(lead[i]);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (words[w]) begin
      for (int b = 0; b < 4; b++) begin
        d  = 8'(words[w] >> (8 * b));
        ck = ck ^ d;
        send_byte(d);
      end
      exp_q.push_back('{addr: 32'(w), data: words[w], cyc: cyc});
    end
`ifdef PMEM_LOADER_CKSUM_EN
    if (words.size() > 0) send_byte(ck);
`endif
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"}, 32'(load_err), 32'(err));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(done));
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(0));
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'(0));
  endtask

  // Offer a sync byte in the terminal state and during the reload pulse; none may be taken
  task automatic do_reload(input string tag, input logic done, input logic err);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check_status({tag, "_hold"}, done, err);
    reload = 1'b1;
    @(posedge clk); #1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    check({tag, "_rl_done"}, 32'(load_done), 32'(0));
    check({tag, "_rl_err"}, 32'(load_err), 32'(0));
    check({tag, "_rl_cpu_rst_n"}, 32'(cpu_rst_n), 32'(0));
    check({tag, "_rl_rx_ready"}, 32'(bus.rx_ready), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  lead[$];
    logic [31:0] w[$];
    logic [31:0] t1[$];
    logic [31:0] c0;

    rst_n        = 1'b0;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    t1 = {32'h1234_5678, 32'hDEAD_BEEF};

    // Reset values
    #2;
    check("rst_rx_ready", 32'(bus.rx_ready), 32'(0));
    check("rst_wr_valid", 32'(bus.ic1_axi_mst_wr_valid), 32'(0));
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'(0));
    check("rst_done", 32'(load_done), 32'(0));
    check("rst_err", 32'(load_err), 32'(0));
    check("rst_wr_addr", bus.ic1_axi_mst_wr_addr, 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_rel_rx_ready0", 32'(bus.rx_ready), 32'(0));
    @(posedge clk); #1;
    check("rst_rel_rx_ready1", 32'(bus.rx_ready), 32'(1));

    // T1 basic two-word image
    lead.delete();
    send_image(lead, 16'd2, t1, 8'h00);
    check_status("t1", 1'b1, 1'b0);
    drain("t1");
    do_reload("t1", 1'b1, 1'b0);

    // T2 sync hunt; the A5 offered during reload must not have been consumed
    lead = {8'h00, 8'hFF, 8'h5A};
    w = {32'h4433_2211};
    send_image(lead, 16'd1, w, 8'h00);
    check_status("t2", 1'b1, 1'b0);
    drain("t2");
    do_reload("t2", 1'b1, 1'b0);

    // T3 length errors: N=0 and N=PMEM_WORDS+1
    lead.delete();
    w.delete();
    send_image(lead, 16'd0, w, 8'h00);
    check_status("t3_zero", 1'b0, 1'b1);
    drain("t3_zero");
    do_reload("t3_zero", 1'b0, 1'b1);
    send_image(lead, 16'(PMEM_WORDS + 1), w, 8'h00);
    check_status("t3_big", 1'b0, 1'b1);
    drain("t3_big");
    do_reload("t3_big", 1'b0, 1'b1);

`ifdef PMEM_LOADER_CKSUM_EN
    // T6 bad checksum: writes still land, then ERROR
    send_image(lead, 16'd2, t1, 8'h05);
    check_status("t6", 1'b0, 1'b1);
    drain("t6");
    do_reload("t6", 1'b0, 1'b1);
`endif

    // T4 full-size image with rx_valid held high: one byte per cycle
    w.delete();
    for (int i = 0; i < int'(PMEM_WORDS); i++) w.push_back($urandom());
    c0 = cyc;
`ifdef PMEM_LOADER_CKSUM_EN
    send_image(lead, 16'(PMEM_WORDS), w, 8'h00);
    check("t4_cycles", cyc - c0, 32'(4 * PMEM_WORDS + 4));
`else
    send_image(lead, 16'(PMEM_WORDS), w, 8'h00);
    check("t4_cycles", cyc - c0, 32'(4 * PMEM_WORDS + 3));
`endif
    check_status("t4", 1'b1, 1'b0);
    drain("t4");
    do_reload("t4", 1'b1, 1'b0);

    // T5 reset after 6 data bytes of a 2-word image
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int b = 0; b < 4; b++) send_byte(8'(32'hCAFE_F00D >> (8 * b)));
    exp_q.push_back('{addr: 32'd0, data: 32'hCAFE_F00D, cyc: cyc});
    send_byte(8'h11);
    send_byte(8'h22);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rx_ready", 32'(bus.rx_ready), 32'(0));
    check("t5_wr_valid", 32'(bus.ic1_axi_mst_wr_valid), 32'(0));
    check("t5_cpu_rst_n", 32'(cpu_rst_n), 32'(0));
    check("t5_done", 32'(load_done), 32'(0));
    check("t5_wr_data", bus.ic1_axi_mst_wr_data, 32'(0));
    check("t5_pending_writes", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_image(lead, 16'd2, t1, 8'h00);
    check_status("t5_reload", 1'b1, 1'b0);
    drain("t5_reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
